// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon output collector: tag width,
// collector FSM states and a constant-foldable ceil(log2) helper.
package ascon_pkg;

  localparam int TAG_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_sipo.sv
// Serial-in/parallel-out register: each enabled edge shifts a bit in at the
// MSB and moves the word right, so the first bit received ends up at bit 0.
module ascon_sipo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         serial_bit,
  output logic [W-1:0] data
);

  if (W == 1) begin : g_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          data <= '0;
      else if (clear)    data <= '0;
      else if (shift_en) data <= serial_bit;
    end
  end else begin : g_wide
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          data <= '0;
      else if (clear)    data <= '0;
      else if (shift_en) data <= {serial_bit, data[W-1:1]};
    end
  end

endmodule

// File: rtl/ascon_out_collector.sv
// Collects the bit-serial ciphertext and tag from the Ascon core into parallel
// words and hands them on over valid/ready. Optional: ASCON_TAG_CHECK_EN.
module ascon_out_collector
  import ascon_pkg::*;
#(
  parameter int Y = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             encryption_readyxSI,
  input  logic             cipher_textxSI,
  input  logic             tagxSI,
  output logic [Y-1:0]     ct_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             out_validxSO,
  input  logic             out_readyxSI,
  output logic             abortxSO
`ifdef ASCON_TAG_CHECK_EN
  ,
  input  logic [TAG_W-1:0] expected_tagxSI,
  output logic             tag_okxSO
`endif
);

  localparam int N  = (Y > TAG_W) ? Y : TAG_W;
  localparam int CW = clog2(N + 1);

  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [CW-1:0] CT_LEN  = CW'(Y);
  localparam logic [CW-1:0] TAG_LEN = CW'(TAG_W);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          fell_q;
  logic          cap_en, clr, abort_n, xfer;
  logic          ct_shift, tag_shift;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    clr     = 1'b0;
    abort_n = 1'b0;
    xfer    = 1'b0;
    case (state)
      S_IDLE: begin
        if (encryption_readyxSI) begin
          state_n = S_SKIP;
          clr     = 1'b1;
        end
      end
      // SKIP spans E0->E1 while bit 0 is presented; the edge leaving it samples bit 0.
      S_SKIP, S_CAPT: begin
        if (!encryption_readyxSI) begin
          state_n = S_IDLE;
          abort_n = 1'b1;
          clr     = 1'b1;
        end else begin
          cap_en  = 1'b1;
          state_n = (cnt == LAST) ? S_OUT : S_CAPT;
        end
      end
      S_OUT: begin
        if (out_readyxSI) begin
          xfer    = 1'b1;
          state_n = (encryption_readyxSI && !fell_q) ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!encryption_readyxSI) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // fell_q remembers a drop of ready during OUT, so the FSM re-arms after the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      fell_q   <= 1'b0;
      abortxSO <= 1'b0;
    end else begin
      abortxSO <= abort_n;
      fell_q   <= (state == S_OUT) && (fell_q || !encryption_readyxSI);
      if (clr)         cnt <= '0;
      else if (cap_en) cnt <= cnt + CW'(1);
    end
  end

  assign out_validxSO = (state == S_OUT);
  assign ct_shift     = cap_en && (cnt < CT_LEN);
  assign tag_shift    = cap_en && (cnt < TAG_LEN);

  ascon_sipo #(.W(Y)) u_ct_sipo (
    .clk        (clk),
    .rst        (rst),
    .clear      (clr),
    .shift_en   (ct_shift),
    .serial_bit (cipher_textxSI),
    .data       (ct_o)
  );

  ascon_sipo #(.W(TAG_W)) u_tag_sipo (
    .clk        (clk),
    .rst        (rst),
    .clear      (clr),
    .shift_en   (tag_shift),
    .serial_bit (tagxSI),
    .data       (tag_o)
  );

`ifdef ASCON_TAG_CHECK_EN
  // Compare against the tag as it will look after the final capture edge.
  logic [TAG_W-1:0] tag_final;
  assign tag_final = tag_shift ? {tagxSI, tag_o[TAG_W-1:1]} : tag_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        tag_okxSO <= 1'b0;
    else if (cap_en && cnt == LAST)  tag_okxSO <= (tag_final == expected_tagxSI);
    else if (xfer)                   tag_okxSO <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ascon_out_collector.sv
// Directed bench for ascon_out_collector: table of full streams on a Y=32
// instance plus hand-written hold, abort, async-reset and Y=160 sequences.
module tb_ascon_out_collector;
  import ascon_pkg::*;

  localparam logic [127:0] TAGV = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enc_ready, ct_bit, tag_bit, out_ready;

  logic [31:0]  ct32;
  logic [127:0] tag32;
  logic         valid32, abort32;
  logic [159:0] ct160;
  logic [127:0] tag160;
  logic         valid160, abort160;
`ifdef ASCON_TAG_CHECK_EN
  logic [127:0] exp_tag;
  logic         ok32, ok160;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [159:0] ct_in;
    logic [127:0] tag_in;
    logic [31:0]  exp_ct;
    logic [127:0] exp_tag;
  } vec_t;

  vec_t         vecs[4];
  logic [159:0] stim_ct;

  always #5 clk = ~clk;

  ascon_out_collector #(.Y(32)) dut32 (
    .clk                 (clk),
    .rst                 (rst),
    .encryption_readyxSI (enc_ready),
    .cipher_textxSI      (ct_bit),
    .tagxSI              (tag_bit),
    .ct_o                (ct32),
    .tag_o               (tag32),
    .out_validxSO        (valid32),
    .out_readyxSI        (out_ready),
    .abortxSO            (abort32)
`ifdef ASCON_TAG_CHECK_EN
    ,
    .expected_tagxSI     (exp_tag),
    .tag_okxSO           (ok32)
`endif
  );

  ascon_out_collector #(.Y(160)) dut160 (
    .clk                 (clk),
    .rst                 (rst),
    .encryption_readyxSI (enc_ready),
    .cipher_textxSI      (ct_bit),
    .tagxSI              (tag_bit),
    .ct_o                (ct160),
    .tag_o               (tag160),
    .out_validxSO        (valid160),
    .out_readyxSI        (out_ready),
    .abortxSO            (abort160)
`ifdef ASCON_TAG_CHECK_EN
    ,
    .expected_tagxSI     (exp_tag),
    .tag_okxSO           (ok160)
`endif
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise ready so the next edge is E0; returns just after E0.
  task automatic begin_enc();
    enc_ready = 1'b1;
    step(1);
  endtask

  // Present bits first..last-1; bit n is sampled at E(n+1). Tag bits past 127 are junk ones.
  task automatic stream(input logic [159:0] ct, input logic [127:0] tg, input int first, input int last);
    for (int n = first; n < last; n++) begin
      ct_bit = ct[n];
      if (n < 128) tag_bit = tg[n];
      else         tag_bit = 1'b1;
      step(1);
    end
  endtask

  task automatic rearm();
    enc_ready = 1'b0;
    ct_bit    = 1'b0;
    tag_bit   = 1'b0;
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF}, TAGV,
                 32'hDEAD_BEEF, TAGV };
    vecs[1] = '{ {128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 32'h0000_0000}, 128'h0,
                 32'h0000_0000, 128'h0 };
    vecs[2] = '{ {128'h0, 32'hFFFF_FFFF}, {128{1'b1}},
                 32'hFFFF_FFFF, {128{1'b1}} };
    vecs[3] = '{ {128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 32'h8000_0001},
                 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                 32'h8000_0001, 128'h8000_0000_0000_0000_0000_0000_0000_0001 };

    enc_ready = 1'b0;
    ct_bit    = 1'b0;
    tag_bit   = 1'b0;
    out_ready = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
    exp_tag   = '0;
`endif

    // Reset state
    step(2);
    check("rst_ct", 160'(ct32), 160'h0);
    check("rst_tag", 160'(tag32), 160'h0);
    check("rst_valid", 160'(valid32), 160'h0);
    check("rst_abort", 160'(abort32), 160'h0);
    check("rst_state", 160'(dut32.state), 160'(S_IDLE));
    check("rst_cnt", 160'(dut32.cnt), 160'h0);
    rst = 1'b1;
    step(1);

    // Table: full streams with the consumer always ready
    for (int i = 0; i < 4; i++) begin
`ifdef ASCON_TAG_CHECK_EN
      exp_tag = vecs[i].exp_tag;
`endif
      begin_enc();
      stream(vecs[i].ct_in, vecs[i].tag_in, 0, 127);
      check("tbl_valid_early", 160'(valid32), 160'h0);
      stream(vecs[i].ct_in, vecs[i].tag_in, 127, 128);
      check("tbl_valid", 160'(valid32), 160'h1);
      check("tbl_ct", 160'(ct32), 160'(vecs[i].exp_ct));
      check("tbl_tag", 160'(tag32), 160'(vecs[i].exp_tag));
`ifdef ASCON_TAG_CHECK_EN
      check("tbl_tag_ok", 160'(ok32), 160'h1);
`endif
      step(1);
      check("tbl_valid_drop", 160'(valid32), 160'h0);
      check("tbl_done", 160'(dut32.state), 160'(S_DONE));
      rearm();
      check("tbl_idle", 160'(dut32.state), 160'(S_IDLE));
    end

    // Consumer stalls 20 cycles: outputs stay put, then exactly one transfer
    out_ready = 1'b0;
    begin_enc();
    stream(vecs[0].ct_in, vecs[0].tag_in, 0, 128);
    check("hold_valid0", 160'(valid32), 160'h1);
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("hold_valid", 160'(valid32), 160'h1);
      check("hold_ct", 160'(ct32), 160'(32'hDEAD_BEEF));
      check("hold_tag", 160'(tag32), 160'(TAGV));
    end
    out_ready = 1'b1;
    step(1);
    check("hold_xfer_valid", 160'(valid32), 160'h0);
    check("hold_xfer_done", 160'(dut32.state), 160'(S_DONE));
    step(3);
    check("hold_no_recap_valid", 160'(valid32), 160'h0);
    check("hold_no_recap_state", 160'(dut32.state), 160'(S_DONE));
    enc_ready = 1'b0;
    step(1);
    check("hold_rearm", 160'(dut32.state), 160'(S_IDLE));
    step(1);

    // Ready falls while waiting in OUT: data still delivered, then straight to IDLE
    out_ready = 1'b0;
    begin_enc();
    stream(vecs[2].ct_in, vecs[2].tag_in, 0, 128);
    enc_ready = 1'b0;
    step(3);
    check("outdrop_valid", 160'(valid32), 160'h1);
    check("outdrop_ct", 160'(ct32), 160'(32'hFFFF_FFFF));
    out_ready = 1'b1;
    step(1);
    check("outdrop_xfer", 160'(valid32), 160'h0);
    check("outdrop_idle", 160'(dut32.state), 160'(S_IDLE));
    rearm();

    // Abort: ready sampled low at E50
    begin_enc();
    stream(vecs[0].ct_in, vecs[0].tag_in, 0, 49);
    enc_ready = 1'b0;
    step(1);
    check("abort_pulse", 160'(abort32), 160'h1);
    check("abort_valid", 160'(valid32), 160'h0);
    check("abort_state", 160'(dut32.state), 160'(S_IDLE));
    check("abort_ct_clr", 160'(ct32), 160'h0);
    step(1);
    check("abort_pulse_end", 160'(abort32), 160'h0);
    check("abort_still_invalid", 160'(valid32), 160'h0);
    stim_ct = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_0001};
    begin_enc();
    stream(stim_ct, TAGV, 0, 128);
    check("restart_valid", 160'(valid32), 160'h1);
    check("restart_ct", 160'(ct32), 160'h1);
    check("restart_tag", 160'(tag32), 160'(TAGV));
    step(1);
    rearm();

    // Async reset between edges mid-capture, then a fresh stream
    begin_enc();
    stream(vecs[0].ct_in, vecs[0].tag_in, 0, 60);
    #3;
    rst = 1'b0;
    #1;
    check("arst_ct", 160'(ct32), 160'h0);
    check("arst_tag", 160'(tag32), 160'h0);
    check("arst_valid", 160'(valid32), 160'h0);
    check("arst_state", 160'(dut32.state), 160'(S_IDLE));
    check("arst_cnt", 160'(dut32.cnt), 160'h0);
    enc_ready = 1'b0;
    rst       = 1'b1;
    step(1);
    begin_enc();
    stream(vecs[3].ct_in, vecs[3].tag_in, 0, 128);
    check("arst_fresh_valid", 160'(valid32), 160'h1);
    check("arst_fresh_ct", 160'(ct32), 160'(32'h8000_0001));
    check("arst_fresh_tag", 160'(tag32), 160'(128'h8000_0000_0000_0000_0000_0000_0000_0001));
    step(1);
    rearm();

    // Y=160 instance: valid after E160, tag ignores bits 128..159
`ifdef ASCON_TAG_CHECK_EN
    exp_tag = TAGV;
`endif
    stim_ct = 160'h1;
    begin_enc();
    stream(stim_ct, TAGV, 0, 159);
    check("y160_valid_early", 160'(valid160), 160'h0);
    stream(stim_ct, TAGV, 159, 160);
    check("y160_valid", 160'(valid160), 160'h1);
    check("y160_ct", ct160, 160'h1);
    check("y160_tag", 160'(tag160), 160'(TAGV));
    check("y160_abort", 160'(abort160), 160'h0);
`ifdef ASCON_TAG_CHECK_EN
    check("y160_tag_ok", 160'(ok160), 160'h1);
`endif
    step(1);
    check("y160_valid_drop", 160'(valid160), 160'h0);
    rearm();

`ifdef ASCON_TAG_CHECK_EN
    // Expected tag differs in bit 127
    exp_tag = TAGV ^ {1'b1, 127'h0};
    begin_enc();
    stream(vecs[0].ct_in, TAGV, 0, 128);
    check("tagchk_valid", 160'(valid32), 160'h1);
    check("tagchk_bad", 160'(ok32), 160'h0);
    step(1);
    check("tagchk_cleared", 160'(ok32), 160'h0);
    rearm();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
